vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_axis_counter.sv | 65 ++++++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and sizing helpers
// used by the timing generator and its per-axis counter.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FPORCH = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BPORCH = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FPORCH = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BPORCH = 33;
    localparam int DEF_X_ROLL   = 20;
    localparam int DEF_Y_ROLL   = 30;

    function automatic int axis_total(input int active, input int fporch,
                                      input int sync, input int bporch);
        return active + fporch + sync + bporch;
    endfunction

    // Minimum width of one bit, so degenerate sizes still give legal vectors
    function automatic int field_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int tile_count(input int total, input int roll);
        return (roll < 1) ? total : (total + roll - 1) / roll;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with tile/offset split and a registered
// sync window. Used once for pixels and once for lines.
module vga_axis_counter import vga_pkg::*; #(
    parameter int TOTAL      = 800,
    parameter int ROLL       = 20,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96,
    parameter bit SYNC_POS   = 1'b0,
    localparam int CW = field_width(TOTAL),
    localparam int HW = field_width(tile_count(TOTAL, ROLL)),
    localparam int LW = field_width(ROLL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic [HW-1:0] hi,
    output logic [LW-1:0] lo,
    output logic          last,
    output logic          sync
);

    localparam logic [CW-1:0] CNT_LAST   = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_FIRST = CW'(SYNC_START);
    localparam logic [CW-1:0] SYNC_END   = CW'(SYNC_START + SYNC_LEN);
    localparam logic [LW-1:0] LO_LAST    = LW'(ROLL - 1);
    localparam logic          ACTIVE_LVL = SYNC_POS;

    logic in_window;

    assign last      = (cnt == CNT_LAST);
    assign in_window = (cnt >= SYNC_FIRST) && (cnt < SYNC_END);

    // Counter wrap clears the tile split too, even mid-tile; sync follows en
    // rather than step so it always lags the counter by one enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            sync <= ~ACTIVE_LVL;
        end else begin
            if (step) begin
                if (last) begin
                    cnt <= '0;
                    hi  <= '0;
                    lo  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                    if (lo == LO_LAST) begin
                        lo <= '0;
                        hi <= hi + HW'(1);
                    end else begin
                        lo <= lo + LW'(1);
                    end
                end
            end
            if (en) begin
                sync <= in_window ? ACTIVE_LVL : ~ACTIVE_LVL;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with tile indices, sync
// outputs, blanking, line/frame start pulses and a sticky vblank interrupt.
module vga_timing_gen import vga_pkg::*; #(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FPORCH  = DEF_H_FPORCH,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BPORCH  = DEF_H_BPORCH,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FPORCH  = DEF_V_FPORCH,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BPORCH  = DEF_V_BPORCH,
    parameter int HSYNC_POS = 0,
    parameter int VSYNC_POS = 0,
    parameter int X_ROLL    = DEF_X_ROLL,
    parameter int Y_ROLL    = DEF_Y_ROLL,
    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FPORCH, H_SYNC, H_BPORCH),
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FPORCH, V_SYNC, V_BPORCH),
    localparam int XW  = field_width(H_TOTAL),
    localparam int YW  = field_width(V_TOTAL),
    localparam int XHW = field_width(tile_count(H_TOTAL, X_ROLL)),
    localparam int XLW = field_width(X_ROLL),
    localparam int YHW = field_width(tile_count(V_TOTAL, Y_ROLL)),
    localparam int YLW = field_width(Y_ROLL)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           irq_clr,
    output logic [XW-1:0]  x,
    output logic [YW-1:0]  y,
    output logic [XHW-1:0] x_hi,
    output logic [XLW-1:0] x_lo,
    output logic [YHW-1:0] y_hi,
    output logic [YLW-1:0] y_lo,
    output logic           hsync,
    output logic           vsync,
    output logic           blank,
    output logic           line_start,
    output logic           frame_start,
    output logic           vblank_irq
);

    generate
        if (H_ACTIVE < 1 || H_FPORCH < 1 || H_SYNC < 1 || H_BPORCH < 1 ||
            V_ACTIVE < 1 || V_FPORCH < 1 || V_SYNC < 1 || V_BPORCH < 1 ||
            X_ROLL < 1 || Y_ROLL < 1) begin : g_bad_params
            $error("vga_timing_gen: timing fields and roll sizes must all be >= 1");
        end
    endgenerate

    localparam logic [XW-1:0] H_ACTIVE_C = XW'(H_ACTIVE);
    localparam logic [YW-1:0] V_ACTIVE_C = YW'(V_ACTIVE);

    logic x_last;
    logic y_last;
    logic vblank_set;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ROLL       (X_ROLL),
        .SYNC_START (H_ACTIVE + H_FPORCH),
        .SYNC_LEN   (H_SYNC),
        .SYNC_POS   (HSYNC_POS != 0)
    ) u_h_axis (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .step (en),
        .cnt  (x),
        .hi   (x_hi),
        .lo   (x_lo),
        .last (x_last),
        .sync (hsync)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ROLL       (Y_ROLL),
        .SYNC_START (V_ACTIVE + V_FPORCH),
        .SYNC_LEN   (V_SYNC),
        .SYNC_POS   (VSYNC_POS != 0)
    ) u_v_axis (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .step (en & x_last),
        .cnt  (y),
        .hi   (y_hi),
        .lo   (y_lo),
        .last (y_last),
        .sync (vsync)
    );

    assign blank      = (x >= H_ACTIVE_C) || (y >= V_ACTIVE_C);
    assign vblank_set = en && (x == '0) && (y == V_ACTIVE_C);

    // Pulses are recomputed every cycle so en=0 forces them low; a new vblank
    // takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank_irq  <= 1'b0;
        end else begin
            line_start  <= en & x_last;
            frame_start <= en & x_last & y_last;
            vblank_irq  <= vblank_set | (vblank_irq & ~irq_clr);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default 640x480 timing, an active-high hsync build and
// a reduced 25x19 raster so whole frames fit in a short run.
module tb_vga_timing_gen;

    typedef struct {
        int x; int y; int xh; int xl; int yh; int yl;
        int hs; int vs; int blank; int ls; int fs; int irq;
    } obs_t;

    typedef struct {
        obs_t d;
        obs_t s;
        obs_t p;
    } exp_t;

    typedef struct {
        int adv; int x; int y; int xh; int xl; int hs; int blank; int ls;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic irq_clr;

    always #5 clk = ~clk;

    logic [9:0] d_x, d_y;
    logic [5:0] d_xh;
    logic [4:0] d_xl, d_yh, d_yl;
    logic       d_hs, d_vs, d_blank, d_ls, d_fs, d_irq;

    logic [9:0] p_x, p_y;
    logic [5:0] p_xh;
    logic [4:0] p_xl, p_yh, p_yl;
    logic       p_hs, p_vs, p_blank, p_ls, p_fs, p_irq;

    logic [4:0] s_x, s_y;
    logic [2:0] s_xh, s_yl;
    logic [1:0] s_xl, s_yh;
    logic       s_hs, s_vs, s_blank, s_ls, s_fs, s_irq;

    vga_timing_gen dut (
        .clk(clk), .rst(rst), .en(en), .irq_clr(irq_clr),
        .x(d_x), .y(d_y), .x_hi(d_xh), .x_lo(d_xl), .y_hi(d_yh), .y_lo(d_yl),
        .hsync(d_hs), .vsync(d_vs), .blank(d_blank),
        .line_start(d_ls), .frame_start(d_fs), .vblank_irq(d_irq)
    );

    vga_timing_gen #(.HSYNC_POS(1)) dut_pos (
        .clk(clk), .rst(rst), .en(en), .irq_clr(irq_clr),
        .x(p_x), .y(p_y), .x_hi(p_xh), .x_lo(p_xl), .y_hi(p_yh), .y_lo(p_yl),
        .hsync(p_hs), .vsync(p_vs), .blank(p_blank),
        .line_start(p_ls), .frame_start(p_fs), .vblank_irq(p_irq)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FPORCH(2), .H_SYNC(4), .H_BPORCH(3),
        .V_ACTIVE(12), .V_FPORCH(2), .V_SYNC(2), .V_BPORCH(3),
        .X_ROLL(4), .Y_ROLL(5)
    ) dut_small (
        .clk(clk), .rst(rst), .en(en), .irq_clr(irq_clr),
        .x(s_x), .y(s_y), .x_hi(s_xh), .x_lo(s_xl), .y_hi(s_yh), .y_lo(s_yl),
        .hsync(s_hs), .vsync(s_vs), .blank(s_blank),
        .line_start(s_ls), .frame_start(s_fs), .vblank_irq(s_irq)
    );

    // Model configuration: index 0 = default timing, index 1 = reduced raster
    int ht[2], vt[2], ha[2], va[2], hss[2], hsl[2], vss[2], vsl[2], xr[2], yr[2];
    int m_pos[2], m_hs[2], m_vs[2], m_ls[2], m_fs[2], m_irq[2];

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int ecount = 0;
    int hs_low = 0, first_hs_x = -1;
    int fs_cnt = 0, first_fs = -1, ls_cnt = 0, vs_low = 0, first_vs = -1;
    int stall_pulses = 0;

    function automatic obs_t packObs(int x, int y, int xh, int xl, int yh, int yl,
                                     int hs, int vs, int blank, int ls, int fs, int irq);
        obs_t o;
        o.x = x; o.y = y; o.xh = xh; o.xl = xl; o.yh = yh; o.yl = yl;
        o.hs = hs; o.vs = vs; o.blank = blank; o.ls = ls; o.fs = fs; o.irq = irq;
        return o;
    endfunction

    function automatic obs_t actualD();
        return packObs(int'(d_x), int'(d_y), int'(d_xh), int'(d_xl), int'(d_yh), int'(d_yl),
                       int'(d_hs), int'(d_vs), int'(d_blank), int'(d_ls), int'(d_fs), int'(d_irq));
    endfunction

    function automatic obs_t actualP();
        return packObs(int'(p_x), int'(p_y), int'(p_xh), int'(p_xl), int'(p_yh), int'(p_yl),
                       int'(p_hs), int'(p_vs), int'(p_blank), int'(p_ls), int'(p_fs), int'(p_irq));
    endfunction

    function automatic obs_t actualS();
        return packObs(int'(s_x), int'(s_y), int'(s_xh), int'(s_xl), int'(s_yh), int'(s_yl),
                       int'(s_hs), int'(s_vs), int'(s_blank), int'(s_ls), int'(s_fs), int'(s_irq));
    endfunction

    function automatic bit sameObs(obs_t a, obs_t b);
        return a.x == b.x && a.y == b.y && a.xh == b.xh && a.xl == b.xl &&
               a.yh == b.yh && a.yl == b.yl && a.hs == b.hs && a.vs == b.vs &&
               a.blank == b.blank && a.ls == b.ls && a.fs == b.fs && a.irq == b.irq;
    endfunction

    function automatic string fmtObs(obs_t o);
        return $sformatf("x=%0d y=%0d xh=%0d xl=%0d yh=%0d yl=%0d hs=%0d vs=%0d blank=%0d ls=%0d fs=%0d irq=%0d",
                         o.x, o.y, o.xh, o.xl, o.yh, o.yl, o.hs, o.vs, o.blank, o.ls, o.fs, o.irq);
    endfunction

    // Expected outputs derived from the absolute raster position
    function automatic obs_t modelObs(int k);
        obs_t o;
        int xx;
        int yy;
        xx = m_pos[k] % ht[k];
        yy = m_pos[k] / ht[k];
        o.x = xx; o.y = yy;
        o.xh = xx / xr[k]; o.xl = xx % xr[k];
        o.yh = yy / yr[k]; o.yl = yy % yr[k];
        o.hs = m_hs[k]; o.vs = m_vs[k];
        o.blank = (xx >= ha[k] || yy >= va[k]) ? 1 : 0;
        o.ls = m_ls[k]; o.fs = m_fs[k]; o.irq = m_irq[k];
        return o;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_pos[k] = 0; m_hs[k] = 1; m_vs[k] = 1;
            m_ls[k] = 0; m_fs[k] = 0; m_irq[k] = 0;
        end
    endtask

    task automatic modelStep(input logic e, input logic c);
        for (int k = 0; k < 2; k++) begin
            int xx;
            int yy;
            int set;
            xx = m_pos[k] % ht[k];
            yy = m_pos[k] / ht[k];
            set = 0;
            if (e) begin
                m_hs[k] = (xx >= hss[k] && xx < hss[k] + hsl[k]) ? 0 : 1;
                m_vs[k] = (yy >= vss[k] && yy < vss[k] + vsl[k]) ? 0 : 1;
                m_ls[k] = (xx == ht[k] - 1) ? 1 : 0;
                m_fs[k] = (xx == ht[k] - 1 && yy == vt[k] - 1) ? 1 : 0;
                set = (xx == 0 && yy == va[k]) ? 1 : 0;
                m_pos[k] = (m_pos[k] + 1) % (ht[k] * vt[k]);
            end else begin
                m_ls[k] = 0;
                m_fs[k] = 0;
            end
            m_irq[k] = (set != 0) ? 1 : (c ? 0 : m_irq[k]);
        end
    endtask

    task automatic compareObs(input string name, input obs_t a, input obs_t r);
        n_cmp++;
        if (!sameObs(a, r)) begin
            n_bad++;
            $display("[TB] FAIL %s actual {%s} required {%s}", name, fmtObs(a), fmtObs(r));
        end
    endtask

    task automatic checkInt(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("[TB] FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checkInt({tag, "_scoreboard_depth"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        compareObs({tag, "_default"}, actualD(), e.d);
        compareObs({tag, "_small"}, actualS(), e.s);
        compareObs({tag, "_hpos"}, actualP(), e.p);
    endtask

    task automatic applyStimulus(input logic e, input logic c);
        exp_t x;
        en = e;
        irq_clr = c;
        modelStep(e, c);
        x.d = modelObs(0);
        x.s = modelObs(1);
        x.p = x.d;
        x.p.hs = 1 - x.d.hs;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        checkOutput($sformatf("cyc%0d", ecount));
        if (e) ecount++;
        if (e && ecount <= 800 && d_hs == 1'b0) begin
            hs_low++;
            if (first_hs_x < 0) first_hs_x = int'(d_x);
        end
        if (e && ecount <= 475) begin
            if (s_fs) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = ecount;
            end
            if (s_ls) ls_cnt++;
            if (!s_vs) begin
                vs_low++;
                if (first_vs < 0) first_vs = ecount;
            end
        end
        if (!e) stall_pulses += int'(d_ls) + int'(d_fs) + int'(s_ls) + int'(s_fs) + int'(p_ls);
    endtask

    task automatic checkReset(input string tag);
        obs_t z;
        obs_t zp;
        z = packObs(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        zp = z;
        zp.hs = 0;
        compareObs({tag, "_default"}, actualD(), z);
        compareObs({tag, "_small"}, actualS(), z);
        compareObs({tag, "_hpos"}, actualP(), zp);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired after %0d comparisons", n_cmp);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[8];
        int n;
        bit ok;

        ht  = '{800, 25};  vt  = '{525, 19};
        ha  = '{640, 16};  va  = '{480, 12};
        hss = '{656, 18};  hsl = '{96, 4};
        vss = '{490, 14};  vsl = '{2, 2};
        xr  = '{20, 4};    yr  = '{30, 5};

        // Checkpoints along the first default line: adv = enabled cycles since previous row
        vecs[0] = '{adv: 639, x: 639, y: 0, xh: 31, xl: 19, hs: 1, blank: 0, ls: 0};
        vecs[1] = '{adv: 1,   x: 640, y: 0, xh: 32, xl: 0,  hs: 1, blank: 1, ls: 0};
        vecs[2] = '{adv: 16,  x: 656, y: 0, xh: 32, xl: 16, hs: 1, blank: 1, ls: 0};
        vecs[3] = '{adv: 1,   x: 657, y: 0, xh: 32, xl: 17, hs: 0, blank: 1, ls: 0};
        vecs[4] = '{adv: 95,  x: 752, y: 0, xh: 37, xl: 12, hs: 0, blank: 1, ls: 0};
        vecs[5] = '{adv: 1,   x: 753, y: 0, xh: 37, xl: 13, hs: 1, blank: 1, ls: 0};
        vecs[6] = '{adv: 46,  x: 799, y: 0, xh: 39, xl: 19, hs: 1, blank: 1, ls: 0};
        vecs[7] = '{adv: 1,   x: 0,   y: 1, xh: 0,  xl: 0,  hs: 1, blank: 0, ls: 1};

        rst = 1'b1;
        en = 1'b0;
        irq_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset_hold");
        modelReset();
        rst = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < vecs[i].adv; j++) applyStimulus(1'b1, 1'b0);
            ok = int'(d_x) == vecs[i].x && int'(d_y) == vecs[i].y &&
                 int'(d_xh) == vecs[i].xh && int'(d_xl) == vecs[i].xl &&
                 int'(d_hs) == vecs[i].hs && int'(d_blank) == vecs[i].blank &&
                 int'(d_ls) == vecs[i].ls;
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("[TB] FAIL vec%0d actual x=%0d y=%0d xh=%0d xl=%0d hs=%0d blank=%0d ls=%0d required x=%0d y=%0d xh=%0d xl=%0d hs=%0d blank=%0d ls=%0d",
                         i, d_x, d_y, d_xh, d_xl, d_hs, d_blank, d_ls,
                         vecs[i].x, vecs[i].y, vecs[i].xh, vecs[i].xl,
                         vecs[i].hs, vecs[i].blank, vecs[i].ls);
            end
        end

        checkInt("hsync_low_cycles", hs_low, 96);
        checkInt("hsync_first_low_x", first_hs_x, 657);
        checkInt("small_frame_start_count", fs_cnt, 1);
        checkInt("small_frame_start_cycle", first_fs, 475);
        checkInt("small_line_start_count", ls_cnt, 19);
        checkInt("small_vsync_low_cycles", vs_low, 50);
        checkInt("small_vsync_first_low", first_vs, 351);

        // Stall mid-line: counters freeze and the line still takes 800 enabled cycles
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b0);
        checkInt("stall_entry_x", int'(d_x), 300);
        for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b0);
        checkInt("stall_hold_x", int'(d_x), 300);
        checkInt("stall_hold_y", int'(d_y), 1);
        checkInt("stall_pulses", stall_pulses, 0);
        n = 0;
        ok = 1'b0;
        while (!ok && n < 1000) begin
            applyStimulus(1'b1, 1'b0);
            n++;
            if (d_ls) ok = 1'b1;
        end
        checkInt("stall_line_remaining_cycles", n, 500);

        // Sticky vblank interrupt on the reduced raster
        applyStimulus(1'b1, 1'b1);
        checkInt("irq_cleared", int'(s_irq), 0);
        n = 0;
        while (m_pos[1] != 300 && n < 1000) begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end
        checkInt("irq_before_vblank", int'(s_irq), 0);
        applyStimulus(1'b1, 1'b1);
        checkInt("irq_set_beats_clear", int'(s_irq), 1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        checkInt("irq_sticky", int'(s_irq), 1);
        applyStimulus(1'b1, 1'b1);
        checkInt("irq_clear_pulse", int'(s_irq), 0);

        // Asynchronous reset in the middle of an hsync pulse
        n = 0;
        while (d_x != 10'd700 && n < 1000) begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end
        checkInt("pre_reset_hsync", int'(d_hs), 0);
        checkInt("pre_reset_hsync_pos", int'(p_hs), 1);
        #2;
        rst = 1'b1;
        #1;
        checkReset("reset_async");
        @(posedge clk);
        #1;
        checkReset("reset_held");
        modelReset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
        checkInt("restart_x", int'(d_x), 4);
        checkInt("restart_y", int'(d_y), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
